// File: rtl/calc1_pkg.sv
// calc1_pkg: shared calc1 opcode, response and request-master FSM types.
package calc1_pkg;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6
  } op_t;
  typedef enum logic [1:0] {
    RESP_NONE     = 2'b00,
    RESP_OK       = 2'b01,
    RESP_ERR      = 2'b10,
    RESP_INTERNAL = 2'b11
  } resp_t;
  typedef enum logic [2:0] {IDLE, OP1, OP2, WAIT, DONE} state_t;
endpackage

// File: rtl/calc1_req_master_if.sv
// calc1_req_master_if: transaction and completion valid/ready channels of one calc1 request port.
interface calc1_req_master_if;
  logic        txn_valid;
  logic        txn_ready;
  logic [3:0]  txn_op;
  logic [31:0] txn_a;
  logic [31:0] txn_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  modport master (
    output txn_valid, txn_op, txn_a, txn_b, rsp_ready,
    input  txn_ready, rsp_valid, rsp_status, rsp_data, rsp_timeout
  );
  modport slave (
    input  txn_valid, txn_op, txn_a, txn_b, rsp_ready,
    output txn_ready, rsp_valid, rsp_status, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/calc1_req_timer.sv
// calc1_req_timer: counts WAIT cycles from zero while start is low; expire flags the last allowed cycle.
module calc1_req_timer #(
  parameter int CYCLES = 64
) (
  input  logic c_clk,
  input  logic reset,
  input  logic start,
  output logic expire
);
  localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge c_clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= start ? '0 : cnt + W'(1);
  assign expire = cnt == W'(CYCLES - 1);
endmodule

// File: rtl/calc1_req_master.sv
// calc1_req_master: serialises op/a/b onto the calc1 two-cycle command protocol and returns the response; CALC1_REQ_TIMEOUT_EN adds a WAIT timeout.
module calc1_req_master
  import calc1_pkg::*;
`ifdef CALC1_REQ_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 64)
`endif
(
  input  logic              c_clk,
  input  logic              reset,
  calc1_req_master_if.slave txn,
  output logic              spurious_resp,
  output logic [3:0]        req_cmd_out,
  output logic [31:0]       req_data_out,
  input  logic [1:0]        out_resp,
  input  logic [31:0]       out_data
);
  state_t      state, state_nx;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q, data_q;
  logic [1:0]  status_q;
  logic        timeout_q, spurious_q, expire, accept, got_resp;
  assign accept   = txn.txn_valid && txn.txn_ready;
  assign got_resp = out_resp != RESP_NONE;
`ifdef CALC1_REQ_TIMEOUT_EN
  calc1_req_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .c_clk (c_clk),
    .reset (reset),
    .start (state != WAIT),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? OP1 : IDLE;
      OP1:     state_nx = OP2;
      OP2:     state_nx = op_q == OP_NOP ? DONE : WAIT;
      WAIT:    state_nx = got_resp || expire ? DONE : WAIT;
      DONE:    state_nx = txn.rsp_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge c_clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      status_q   <= '0;
      data_q     <= '0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state      <= state_nx;
      spurious_q <= got_resp && state != WAIT;
      if (accept) begin
        op_q <= txn.txn_op;
        a_q  <= txn.txn_a;
        b_q  <= txn.txn_b;
      end
      if (state == OP2 && op_q == OP_NOP) begin
        status_q  <= RESP_NONE;
        data_q    <= '0;
        timeout_q <= 1'b0;
      end
      // a response arriving on the expiry cycle takes priority over the timeout
      if (state == WAIT && (got_resp || expire)) begin
        status_q  <= got_resp ? out_resp : RESP_NONE;
        data_q    <= got_resp ? out_data : '0;
        timeout_q <= !got_resp;
      end
    end
  assign txn.txn_ready   = state == IDLE && !reset;
  assign txn.rsp_valid   = state == DONE;
  assign txn.rsp_status  = status_q;
  assign txn.rsp_data    = data_q;
  assign txn.rsp_timeout = timeout_q;
  assign spurious_resp   = spurious_q;
  assign req_cmd_out     = state == OP1 ? op_q : 4'd0;
  assign req_data_out    = state == OP1 ? a_q : state == OP2 ? b_q : 32'd0;
endmodule

// File: tb/tb_calc1_req_master.sv
// tb_calc1_req_master: directed checks of the calc1 request master against hand-computed values.
module tb_calc1_req_master;
  import calc1_pkg::*;
  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic        spurious_resp;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  out_resp = 2'b00;
  logic [31:0] out_data = 32'd0;
  int          checks = 0;
  int          failures = 0;
  calc1_req_master_if bus();
  always #5 c_clk = ~c_clk;
`ifdef CALC1_REQ_TIMEOUT_EN
  calc1_req_master #(.TIMEOUT_CYCLES(8)) dut (
`else
  calc1_req_master dut (
`endif
    .c_clk        (c_clk),
    .reset        (reset),
    .txn          (bus),
    .spurious_resp(spurious_resp),
    .req_cmd_out  (req_cmd_out),
    .req_data_out (req_data_out),
    .out_resp     (out_resp),
    .out_data     (out_data)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    chk("idle_ready", 32'(bus.txn_ready), 32'd1);
    bus.txn_valid = 1'b1;
    bus.txn_op    = op;
    bus.txn_a     = a;
    bus.txn_b     = b;
    @(negedge c_clk);
    bus.txn_valid = 1'b0;
    chk("op1_cmd", 32'(req_cmd_out), 32'(op));
    chk("op1_data", req_data_out, a);
    chk("op1_busy", 32'(bus.txn_ready), 32'd0);
    @(negedge c_clk);
    chk("op2_cmd", 32'(req_cmd_out), 32'd0);
    chk("op2_data", req_data_out, b);
    @(negedge c_clk);
    chk("n3_valid", 32'(bus.rsp_valid), op == 4'd0 ? 32'd1 : 32'd0);
    chk("n3_cmd", 32'(req_cmd_out), 32'd0);
    chk("n3_data", req_data_out, 32'd0);
  endtask
  task automatic respond(input logic [1:0] r, input logic [31:0] d, input int delay);
    repeat (delay) @(negedge c_clk);
    chk("no_early_valid", 32'(bus.rsp_valid), 32'd0);
    out_resp = r;
    out_data = d;
    @(negedge c_clk);
    out_resp = 2'b00;
    out_data = 32'd0;
    chk("rsp_valid_rise", 32'(bus.rsp_valid), 32'd1);
  endtask
  task automatic complete(input logic [1:0] st, input logic [31:0] d, input logic to);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_status", 32'(bus.rsp_status), 32'(st));
    chk("rsp_data", bus.rsp_data, d);
    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(to));
    bus.rsp_ready = 1'b1;
    @(negedge c_clk);
    bus.rsp_ready = 1'b0;
    bus.txn_valid = 1'b0;
    chk("after_hs_valid", 32'(bus.rsp_valid), 32'd0);
    chk("after_hs_ready", 32'(bus.txn_ready), 32'd1);
    chk("after_hs_spur", 32'(spurious_resp), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.txn_valid = 1'b0;
    bus.txn_op    = 4'd0;
    bus.txn_a     = 32'd0;
    bus.txn_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge c_clk);
    chk("rst_txn_ready", 32'(bus.txn_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_cmd", 32'(req_cmd_out), 32'd0);
    chk("rst_spur", 32'(spurious_resp), 32'd0);
    reset = 1'b0;
    #1 chk("rel_txn_ready", 32'(bus.txn_ready), 32'd1);
    @(negedge c_clk);
    send(OP_ADD, 32'hA, 32'h4);
    respond(RESP_OK, 32'hE, 3);
    complete(RESP_OK, 32'hE, 1'b0);
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    respond(RESP_ERR, 32'h0, 1);
    complete(RESP_ERR, 32'h0, 1'b0);
    send(OP_SHR, 32'hFFFF_FFFF, 32'h4);
    respond(RESP_OK, 32'h0FFF_FFFF, 2);
    bus.txn_valid = 1'b1;
    bus.txn_op    = OP_SUB;
    bus.txn_a     = 32'h55;
    bus.txn_b     = 32'h11;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_data", bus.rsp_data, 32'h0FFF_FFFF);
      chk("bp_status", 32'(bus.rsp_status), 32'(RESP_OK));
      chk("bp_ready_low", 32'(bus.txn_ready), 32'd0);
      chk("bp_no_cmd", 32'(req_cmd_out), 32'd0);
      @(negedge c_clk);
    end
    complete(RESP_OK, 32'h0FFF_FFFF, 1'b0);
    @(negedge c_clk);
    chk("bp_not_accepted", 32'(req_cmd_out), 32'd0);
    send(OP_NOP, 32'h1234, 32'h5678);
    complete(RESP_NONE, 32'h0, 1'b0);
`ifdef CALC1_REQ_TIMEOUT_EN
    begin
      int n = 0;
      send(OP_ADD, 32'h1, 32'h2);
      while (!bus.rsp_valid && n < 40) begin
        @(negedge c_clk);
        n++;
      end
      chk("to_wait_cycles", 32'(n), 32'd8);
      complete(RESP_NONE, 32'h0, 1'b1);
      out_resp = RESP_OK;
      out_data = 32'h3;
      @(negedge c_clk);
      out_resp = RESP_NONE;
      out_data = 32'd0;
      chk("late_spur", 32'(spurious_resp), 32'd1);
      chk("late_no_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge c_clk);
      chk("late_spur_end", 32'(spurious_resp), 32'd0);
    end
`endif
    send(OP_SUB, 32'h9, 32'h3);
`ifndef CALC1_REQ_TIMEOUT_EN
    repeat (70) @(negedge c_clk);
    chk("no_to_valid", 32'(bus.rsp_valid), 32'd0);
    chk("no_to_flag", 32'(bus.rsp_timeout), 32'd0);
`else
    @(negedge c_clk);
`endif
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_txn_ready", 32'(bus.txn_ready), 32'd0);
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_cmd", 32'(req_cmd_out), 32'd0);
    chk("mid_rst_data", req_data_out, 32'd0);
    chk("mid_rst_status", 32'(bus.rsp_status), 32'd0);
    chk("mid_rst_rdata", bus.rsp_data, 32'd0);
    chk("mid_rst_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("mid_rst_spur", 32'(spurious_resp), 32'd0);
    @(negedge c_clk);
    reset = 1'b0;
    #1 chk("mid_rel_ready", 32'(bus.txn_ready), 32'd1);
    @(negedge c_clk);
    out_resp = RESP_OK;
    out_data = 32'h6;
    @(negedge c_clk);
    out_resp = RESP_NONE;
    out_data = 32'd0;
    chk("post_rst_spur", 32'(spurious_resp), 32'd1);
    chk("post_rst_no_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge c_clk);
    chk("post_rst_spur_end", 32'(spurious_resp), 32'd0);
    chk("post_rst_idle", 32'(bus.txn_ready), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
